// File: rtl/game_pkg.sv
// Shared types and constants for the game-over controller.
// Holds the FSM state enum and the default retry keycode.
package game_pkg;

  typedef enum logic [2:0] {
    GO_PLAY,
    GO_DYING,
    GO_OVER,
    GO_ARMED,
    GO_RESTART
  } go_state_t;

  localparam logic [7:0] KEY_R = 8'h15;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: one-cycle pulse on each
// falling edge of the active-low vertical sync.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset_n,
  input  logic vs,
  output logic frame_tick
);

  logic vs_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) vs_q <= 1'b1;
    else          vs_q <= vs;
  end

  assign frame_tick = vs_q & ~vs;

endmodule

// File: rtl/game_over_ctrl.sv
// Death / game-over / retry sequencer with registered outputs.
// Optional retry-prompt blink enabled by defining RETRY_BLINK_EN.
module game_over_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEATH_DELAY_FRAMES = 60,
  parameter int unsigned MIN_SHOW_FRAMES    = 30,
  parameter logic [7:0]  RETRY_KEY          = KEY_R,
  parameter int unsigned BLINK_FRAMES       = 16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       death_evt,
  input  logic [7:0] keycode,
  output logic       freeze_game,
  output logic       show_overlay,
  output logic       prompt_on,
  output logic       restart_pulse
);

  localparam logic [7:0] DYING_LAST =
    8'(DEATH_DELAY_FRAMES - 1);
  localparam logic [7:0] OVER_LAST =
    8'(MIN_SHOW_FRAMES - 1);

  go_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] key_q;
  logic       frame_tick;
  logic       retry_edge;

  logic freeze_d, overlay_d;
  logic restart_d, prompt_d;

  frame_tick_gen u_tick (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .vs         (vs),
    .frame_tick (frame_tick)
  );

  // A held key never re-arms: only a fresh press counts.
  assign retry_edge = (key_q != RETRY_KEY) &&
                      (keycode == RETRY_KEY);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= GO_PLAY;
      cnt_q   <= 8'd0;
      key_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= keycode;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      GO_PLAY: begin
        if (death_evt) begin
          state_d = GO_DYING;
          cnt_d   = 8'd0;
        end
      end
      GO_DYING: begin
        if (frame_tick) begin
          if (cnt_q == DYING_LAST) begin
            state_d = GO_OVER;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      GO_OVER: begin
        if (frame_tick) begin
          if (cnt_q == OVER_LAST) begin
            state_d = GO_ARMED;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      GO_ARMED: begin
        if (retry_edge) begin
          state_d = GO_RESTART;
        end else if (frame_tick) begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      GO_RESTART: begin
        state_d = GO_PLAY;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = GO_PLAY;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs decode the next state so they land with it.
  always_comb begin
    freeze_d  = 1'b0;
    overlay_d = 1'b0;
    restart_d = 1'b0;
    case (state_d)
      GO_DYING: begin
        freeze_d = 1'b1;
      end
      GO_OVER, GO_ARMED: begin
        freeze_d  = 1'b1;
        overlay_d = 1'b1;
      end
      GO_RESTART: begin
        freeze_d  = 1'b1;
        restart_d = 1'b1;
      end
      default: begin
        freeze_d = 1'b0;
      end
    endcase
  end

`ifdef RETRY_BLINK_EN
  localparam logic [7:0] BLINK_LAST =
    8'(BLINK_FRAMES - 1);

  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (state_d != GO_ARMED) begin
      blink_cnt_d = 8'd0;
      blink_d     = 1'b0;
    end else if (state_q != GO_ARMED) begin
      blink_cnt_d = 8'd0;
      blink_d     = 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign prompt_d = blink_d;
`else
  assign prompt_d = overlay_d;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      freeze_game   <= 1'b0;
      show_overlay  <= 1'b0;
      prompt_on     <= 1'b0;
      restart_pulse <= 1'b0;
    end else begin
      freeze_game   <= freeze_d;
      show_overlay  <= overlay_d;
      prompt_on     <= prompt_d;
      restart_pulse <= restart_d;
    end
  end

endmodule

// File: tb/tb_game_over_ctrl.sv
// Testbench for game_over_ctrl: vector table, directed
// scenarios and random stimulus against a frame-count model.
module tb_game_over_ctrl;

  localparam int D = 60;
  localparam int M = 30;
  localparam int B = 16;
  localparam logic [7:0] R = 8'h15;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       vs = 1'b1;
  logic       death_evt = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       freeze_game, show_overlay;
  logic       prompt_on, restart_pulse;

  always #5 Clk = ~Clk;

  game_over_ctrl dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .vs            (vs),
    .death_evt     (death_evt),
    .keycode       (keycode),
    .freeze_game   (freeze_game),
    .show_overlay  (show_overlay),
    .prompt_on     (prompt_on),
    .restart_pulse (restart_pulse)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: dead flag plus frame ticks counted since death.
  bit         m_dead, m_restart, m_prev_vs;
  int         m_ticks, m_armed_ticks;
  logic [7:0] m_prev_key;

  function automatic void m_reset();
    m_dead = 0;
    m_restart = 0;
    m_prev_vs = 1;
    m_ticks = 0;
    m_armed_ticks = 0;
    m_prev_key = 8'h00;
  endfunction

  function automatic void m_step(
    input bit v, input bit d, input logic [7:0] k
  );
    bit tick, armed;
    tick  = m_prev_vs && !v;
    armed = m_dead && (m_ticks >= D + M);
    if (m_restart) begin
      m_restart = 0;
    end else if (!m_dead) begin
      if (d) begin
        m_dead = 1;
        m_ticks = 0;
      end
    end else if (armed && m_prev_key != R && k == R) begin
      m_dead = 0;
      m_restart = 1;
    end else if (tick) begin
      if (armed) m_armed_ticks++;
      m_ticks++;
      if (m_ticks == D + M) m_armed_ticks = 0;
    end
    m_prev_vs = v;
    m_prev_key = k;
  endfunction

  function automatic logic [3:0] m_out();
    bit ov, ar, pr;
    ov = m_dead && (m_ticks >= D);
    ar = m_dead && (m_ticks >= D + M);
`ifdef RETRY_BLINK_EN
    pr = ar && (((m_armed_ticks / B) % 2) == 0);
`else
    pr = ov;
`endif
    return {m_dead || m_restart, ov, m_restart, pr};
  endfunction

  function automatic logic [3:0] dut_out();
    return {freeze_game, show_overlay,
            restart_pulse, prompt_on};
  endfunction

  task automatic check(
    input string nm,
    input logic [3:0] act,
    input logic [3:0] exp
  );
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got %b want %b (frz/ovl/rst/prm)",
               nm, $time, act, exp);
    end
  endtask

  task automatic cyc(
    input bit v, input bit d, input logic [7:0] k
  );
    vs = v;
    death_evt = d;
    keycode = k;
    @(posedge Clk);
    m_step(v, d, k);
    #1;
    check("model", dut_out(), m_out());
  endtask

  task automatic frames(input int n, input logic [7:0] k);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, k);
      cyc(1, 0, k);
      cyc(1, 0, k);
      cyc(1, 0, k);
    end
  endtask

  task automatic do_reset();
    vs = 1'b1;
    death_evt = 1'b0;
    keycode = 8'h00;
    #2;
    Reset_n = 1'b0;
    #1;
    check("reset_async", dut_out(), 4'b0000);
    m_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_hold", dut_out(), 4'b0000);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  typedef struct {
    bit         v;
    bit         d;
    logic [7:0] k;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] rk;

  initial begin
    tbl[0] = '{1, 0, 8'h00, 4'b0000};
    tbl[1] = '{0, 0, 8'h00, 4'b0000};
    tbl[2] = '{1, 1, 8'h15, 4'b1000};
    tbl[3] = '{0, 1, 8'h00, 4'b1000};
    tbl[4] = '{1, 0, 8'h15, 4'b1000};
    tbl[5] = '{0, 0, 8'h00, 4'b1000};

    m_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].k);
      check("table", dut_out(), tbl[i].exp);
    end

    // Death to overlay after 60 frames.
    do_reset();
    cyc(1, 1, 8'h00);
    check("freeze_next", {3'b0, freeze_game}, 4'd1);
    frames(D - 1, 8'h00);
    check("ovl_before", {3'b0, show_overlay}, 4'd0);
    cyc(0, 0, 8'h00);
    check("ovl_at_60", {3'b0, show_overlay}, 4'd1);

    // Key pressed in OVER and held: no restart.
    frames(10, 8'h00);
    frames(40, R);
    cyc(1, 0, 8'h00);
    cyc(1, 0, R);
    check("retry_press", dut_out(), 4'b1010);
    cyc(1, 0, R);
    check("back_play", dut_out(), 4'b0000);

    // Edge from a different key counts.
    cyc(1, 1, 8'h00);
    frames(D + M + 1, 8'h00);
    cyc(1, 0, 8'h07);
    cyc(1, 0, R);
    check("edge_from_07", dut_out(), 4'b1010);
    cyc(1, 0, R);
    check("after_07", dut_out(), 4'b0000);

    // Retry key held across the whole sequence.
    cyc(1, 1, R);
    frames(D + M + 1, R);
    cyc(1, 0, R);
    cyc(1, 0, R);
    check("held_no_pulse", {3'b0, restart_pulse}, 4'd0);

    // Prompt behaviour while armed, then async abort.
    frames(3 * B + 5, 8'h00);
    cyc(1, 0, 8'h00);
    do_reset();
    cyc(1, 0, R);
    check("abort_play", dut_out(), 4'b0000);

    // Second death mid-DYING is ignored.
    cyc(1, 1, 8'h00);
    frames(20, 8'h00);
    cyc(1, 1, 8'h00);
    frames(D - 21, 8'h00);
    check("ovl_2nd_before", {3'b0, show_overlay}, 4'd0);
    cyc(0, 0, 8'h00);
    check("ovl_2nd_at_60", {3'b0, show_overlay}, 4'd1);

    // Random traffic.
    do_reset();
    rk = 8'h00;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: rk = 8'h00;
          1: rk = R;
          default: rk = 8'h07;
        endcase
      end
      cyc($urandom_range(3) != 0,
          $urandom_range(60) == 0, rk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
